regfile_writeback_arbiter: RTL
==============================

// Module: regfile_writeback_arbiter
// PURPOSE
//  - Shares the single register-file write port (RD/WriteEnable/D) among NUM_REQ writeback sources (ALU, load unit, CSR unit).
//  - Round-robin grant with a valid/ready handshake per requester.
//  - Registered write stage drives registerfile i_RD/i_WriteEnable/i_D directly.
//  - Sits between the execute/memory writeback sources and registerfile.
// PARAMETERS
//  NUM_REQ     3   number of writeback requesters (2..8)
//  DATA_WIDTH  32  register data width
//  ADDR_WIDTH  5   register index width (32 architectural registers, x0 hardwired zero)
// PORTS
//  i_Clock        in   1                   core clock, all state on posedge
//  i_Reset        in   1                   synchronous, active-high reset
//  i_Hold         in   1                   1 = suppress all grants (port borrowed, e.g. debug write)
//  i_ReqValid     in   NUM_REQ             requester k has a pending write
//  i_ReqRD        in   NUM_REQ*ADDR_WIDTH  destination register of requester k (slice k)
//  i_ReqD         in   NUM_REQ*DATA_WIDTH  write data of requester k (slice k)
//  o_ReqReady     out  NUM_REQ             one-hot grant; transfer when valid & ready
//  o_RD           out  ADDR_WIDTH          to registerfile i_RD
//  o_WriteEnable  out  1                   to registerfile i_WriteEnable
//  o_D            out  DATA_WIDTH          to registerfile i_D
//  o_StallCount   out  NUM_REQ*16          per-requester stall counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, active-high): o_RD=0, o_WriteEnable=0, o_D=0, RR pointer=0, stall counters=0.
//    o_ReqReady=0 while i_Reset=1.
//  - Grant (combinational): o_ReqReady is one-hot or zero.
//    Grant goes to the first valid requester at or after the RR pointer, scanning upward with wrap at NUM_REQ-1 -> 0.
//    o_ReqReady=0 when i_Reset=1, i_Hold=1, or no request is valid.
//  - o_ReqReady[k] never asserts without i_ReqValid[k]; ready does not depend on o_* state (no backpressure from the write stage).
//  - Requester contract: once valid is raised, hold valid, RD and D stable until the transfer cycle. Dropping valid early is a protocol error; the arbiter does not check for it.
//  - Transfer on posedge when valid[k] & ready[k]:
//    o_RD <= RD[k]; o_D <= D[k]; o_WriteEnable <= (RD[k] != 0).
//    Pointer <= (k == NUM_REQ-1) ? 0 : k+1.
//  - Writes to x0 are consumed (ready asserted) but produce o_WriteEnable=0; o_RD/o_D still update.
//  - No-transfer cycle: o_WriteEnable <= 0, o_RD <= 0, o_D <= 0; pointer unchanged.
//  - Latency: request accepted in cycle N -> registerfile write occurs on the posedge ending cycle N+1.
//    Throughput: one write per cycle.
//  - Simultaneous requests: exactly one granted per cycle. Fairness: with all NUM_REQ valid, each is granted once per NUM_REQ cycles.
//  - i_Hold rising with o_WriteEnable=1: the already-registered write still completes; only new grants are blocked.
//  - Reset mid-operation: a pending registered write is discarded (o_WriteEnable forced 0 on the reset edge). Pending requests are not granted until reset deasserts.
// CONFIGURATION
//  - Macro REGFILE_WB_STALL_COUNT_EN.
//  - Defined: counter k increments by 1 each posedge where i_ReqValid[k] & !o_ReqReady[k] & !i_Reset.
//    16-bit saturating at 0xFFFF; cleared only by reset.
//  - Undefined: o_StallCount tied to 0; no counter flops are instantiated.
// STRUCTURE
//  - Package regfile_wb_pkg:
//    localparams REG_ADDR_WIDTH=5, REG_DATA_WIDTH=32, STALL_CNT_WIDTH=16.
//    typedef struct packed {logic [4:0] rd; logic [31:0] d;} wb_req_t.
//    function rr_next(ptr, n) for the pointer wrap.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr, enable; output one-hot gnt[N].
//    Purely combinational; the pointer register lives in the parent.
// TESTING (bench also instantiates registerfile, reading back through RS1/RS2)
//  1. Single requester: req0 valid, RD=1, D=0xFEEDFACE -> ready0 same cycle; next cycle WE=1, RD=1; later read x1 = 0xFEEDFACE.
//  2. All 3 valid from reset (RD=2/3/4, D=0xA/0xB/0xC) -> grants in order req0, req1, req2 on consecutive cycles; x2/x3/x4 read 0xA/0xB/0xC.
//  3. Fairness: req0 and req2 held valid for 6 cycles -> grants alternate 0,2,0,2,0,2; req1 never readied.
//  4. x0 write: req1 RD=0, D=0xDEADBEEF -> ready1=1, WE stays 0; x0 reads 0.
//  5. i_Hold=1 for 3 cycles with req0 valid -> ready0=0; with the macro defined StallCount[0]=3; grant is issued on the cycle after hold drops.
//  6. Reset asserted the cycle after a transfer of RD=5, D=0x12345678 -> WE=0 at the next edge; x5 unchanged; pointer=0 after reset.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared widths, the writeback request record and the round-robin pointer
// wrap helper for the register-file writeback arbiter.
package regfile_wb_pkg;

    localparam int REG_ADDR_WIDTH  = 5;
    localparam int REG_DATA_WIDTH  = 32;
    localparam int STALL_CNT_WIDTH = 16;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } wb_req_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping from N-1 to 0. The pointer register lives in the parent.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt
);

    logic found;

    // NOTE: every signal written here gets a value before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // First pass covers ptr..N-1, second pass the wrapped range 0..ptr-1.
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && (k >= int'(ptr))) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!enable) begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources with a
// round-robin valid/ready handshake. Optional stall counters: REGFILE_WB_STALL_COUNT_EN.
module regfile_writeback_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset,
    input  logic                                i_Hold,
    input  logic [NUM_REQ-1:0]                  i_ReqValid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       i_ReqRD,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       i_ReqD,
    output logic [NUM_REQ-1:0]                  o_ReqReady,
    output logic [ADDR_WIDTH-1:0]               o_RD,
    output logic                                o_WriteEnable,
    output logic [DATA_WIDTH-1:0]               o_D,
    output logic [NUM_REQ*STALL_CNT_WIDTH-1:0]  o_StallCount
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    gnt;
    logic                  grant_en;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  we_q, we_d;

    // Grants depend only on requests, hold and reset, never on the write stage.
    assign grant_en = !i_Reset && !i_Hold;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (i_ReqValid),
        .ptr    (ptr_q),
        .enable (grant_en),
        .gnt    (gnt)
    );

    assign o_ReqReady = gnt;

    always_comb begin
        rd_d  = '0;
        d_d   = '0;
        we_d  = 1'b0;
        ptr_d = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                rd_d  = i_ReqRD[k*ADDR_WIDTH +: ADDR_WIDTH];
                d_d   = i_ReqD[k*DATA_WIDTH +: DATA_WIDTH];
                we_d  = (rd_d != '0);
                ptr_d = PTR_W'(rr_next(unsigned'(k), unsigned'(NUM_REQ)));
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            ptr_q <= '0;
            rd_q  <= '0;
            d_q   <= '0;
            we_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            rd_q  <= rd_d;
            d_q   <= d_d;
            we_q  <= we_d;
        end
    end

    assign o_RD          = rd_q;
    assign o_D           = d_q;
    assign o_WriteEnable = we_q;

`ifdef REGFILE_WB_STALL_COUNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q [NUM_REQ];
    logic [STALL_CNT_WIDTH-1:0] stall_d [NUM_REQ];

    // A requester stalls on any cycle it is valid but not granted; counts saturate.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            stall_d[k] = stall_q[k];
            if (i_ReqValid[k] && !gnt[k] && (stall_q[k] != '1)) begin
                stall_d[k] = stall_q[k] + STALL_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_Reset) begin
                stall_q[k] <= '0;
            end else begin
                stall_q[k] <= stall_d[k];
            end
        end
    end

    always_comb begin
        o_StallCount = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_StallCount[k*STALL_CNT_WIDTH +: STALL_CNT_WIDTH] = stall_q[k];
        end
    end
`else
    assign o_StallCount = '0;
`endif

endmodule
